// File: rtl/hue_histogram.sv
// Hue histogram: bins 0..239 hue samples into 16 counters per frame, then
// snapshots them at frame_end and streams the snapshot out over valid/ready.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no dump pending; frame_end snapshots live bins and starts DUMP
// DUMP    | streaming shadow[idx]; a frame_end here is an overrun
module hue_histogram #(
   parameter int CNT_WIDTH = 20,
   parameter int NUM_BINS  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           hue,
   input  logic                 hue_valid,
   input  logic                 frame_end,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3:0]           out_bin,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_last,
   output logic                 bad_hue,
   output logic                 overrun
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_DUMP = 1'b1;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [3:0]           LAST_BIN = 4'(NUM_BINS - 1);
   localparam logic [7:0]           HUE_LIM  = 8'd240;

   logic [0:0]           state_q, state_d;
   logic [3:0]           idx_q, idx_d;
   logic                 bad_hue_q, bad_hue_d;
   logic                 overrun_q, overrun_d;
   logic [CNT_WIDTH-1:0] live_q   [NUM_BINS];
   logic [CNT_WIDTH-1:0] live_d   [NUM_BINS];
   logic [CNT_WIDTH-1:0] shadow_q [NUM_BINS];
   logic [CNT_WIDTH-1:0] shadow_d [NUM_BINS];

   logic [3:0] hue_bin;
   logic       hue_legal;

   // floor(hue/15) as a threshold ladder; exact across 0..239 without a divider
   always_comb begin
      hue_bin = 4'd0;
      for (int k = 1; k < NUM_BINS; k++) begin
         if (hue >= 8'(15 * k)) begin
            hue_bin = 4'(k);
         end
      end
   end

   assign hue_legal = (hue < HUE_LIM);

   always_comb begin
      live_d    = live_q;
      shadow_d  = shadow_q;
      state_d   = state_q;
      idx_d     = idx_q;
      bad_hue_d = bad_hue_q;
      overrun_d = overrun_q;

      if (hue_valid) begin
         if (!hue_legal) begin
            bad_hue_d = 1'b1;
         end else if (live_q[hue_bin] != CNT_MAX) begin
            live_d[hue_bin] = live_q[hue_bin] + 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (frame_end) begin
               // live_d already holds any sample coincident with frame_end
               shadow_d = live_d;
               state_d  = ST_DUMP;
               idx_d    = 4'd0;
            end
         end
         ST_DUMP: begin
            if (out_ready) begin
               if (idx_q == LAST_BIN) begin
                  state_d = ST_IDLE;
                  idx_d   = 4'd0;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
            if (frame_end) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = 4'd0;
         end
      endcase

      if (frame_end) begin
         for (int i = 0; i < NUM_BINS; i++) begin
            live_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= 4'd0;
         bad_hue_q <= 1'b0;
         overrun_q <= 1'b0;
         for (int i = 0; i < NUM_BINS; i++) begin
            live_q[i]   <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         bad_hue_q <= bad_hue_d;
         overrun_q <= overrun_d;
         live_q    <= live_d;
         shadow_q  <= shadow_d;
      end
   end

   assign out_valid = (state_q == ST_DUMP);
   assign out_bin   = out_valid ? idx_q : 4'd0;
   assign out_count = out_valid ? shadow_q[idx_q] : '0;
   assign out_last  = out_valid && (idx_q == LAST_BIN);
   assign bad_hue   = bad_hue_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_hue_histogram.sv
// Directed and random bench for hue_histogram; two instances (20-bit and
// 4-bit counters) share stimulus and are compared with a per-frame count model.
module tb_hue_histogram;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  hue = 8'd0;
   logic        hue_valid = 1'b0;
   logic        frame_end = 1'b0;
   logic        out_ready = 1'b0;

   logic        out_valid_a, out_last_a, bad_hue_a, overrun_a;
   logic [3:0]  out_bin_a;
   logic [19:0] out_count_a;
   logic        out_valid_b, out_last_b, bad_hue_b, overrun_b;
   logic [3:0]  out_bin_b;
   logic [3:0]  out_count_b;

   int n_checks = 0;
   int n_err    = 0;

   int live_m   [16];
   int shadow_m [16];
   bit dump_m;
   int idx_m;
   bit bad_m;
   bit ovr_m;

   always #5 clk = ~clk;

   hue_histogram dut_a (
      .clk(clk), .rst(rst), .hue(hue), .hue_valid(hue_valid),
      .frame_end(frame_end), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_bin(out_bin_a), .out_count(out_count_a), .out_last(out_last_a),
      .bad_hue(bad_hue_a), .overrun(overrun_a)
   );

   hue_histogram #(.CNT_WIDTH(4)) dut_b (
      .clk(clk), .rst(rst), .hue(hue), .hue_valid(hue_valid),
      .frame_end(frame_end), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_bin(out_bin_b), .out_count(out_count_b), .out_last(out_last_b),
      .bad_hue(bad_hue_b), .overrun(overrun_b)
   );

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", 32'(out_valid_a), 32'(dump_m));
      chk("out_valid_w4", 32'(out_valid_b), 32'(dump_m));
      chk("bad_hue", 32'(bad_hue_a), 32'(bad_m));
      chk("bad_hue_w4", 32'(bad_hue_b), 32'(bad_m));
      chk("overrun", 32'(overrun_a), 32'(ovr_m));
      chk("overrun_w4", 32'(overrun_b), 32'(ovr_m));
      if (dump_m) begin
         chk("out_bin", 32'(out_bin_a), 32'(idx_m));
         chk("out_bin_w4", 32'(out_bin_b), 32'(idx_m));
         chk("out_last", 32'(out_last_a), 32'(idx_m == 15));
         chk($sformatf("out_count[%0d]", idx_m), 32'(out_count_a), 32'(sat(shadow_m[idx_m], 20)));
         chk($sformatf("out_count_w4[%0d]", idx_m), 32'(out_count_b), 32'(sat(shadow_m[idx_m], 4)));
      end
   endtask

   // Apply the histogram rules to the inputs presented at this edge, then clock.
   task automatic step();
      bit was_dump;
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            live_m[i]   = 0;
            shadow_m[i] = 0;
         end
         dump_m = 0;
         idx_m  = 0;
         bad_m  = 0;
         ovr_m  = 0;
      end else begin
         was_dump = dump_m;
         if (hue_valid) begin
            if (int'(hue) >= 240) bad_m = 1;
            else live_m[int'(hue) / 15]++;
         end
         if (was_dump && out_ready) begin
            if (idx_m == 15) dump_m = 0;
            else idx_m++;
         end
         if (frame_end) begin
            if (!was_dump) begin
               shadow_m = live_m;
               dump_m   = 1;
               idx_m    = 0;
            end else begin
               ovr_m = 1;
            end
            for (int i = 0; i < 16; i++) live_m[i] = 0;
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic pix(input int h);
      hue       = 8'(h);
      hue_valid = 1'b1;
      step();
      hue_valid = 1'b0;
   endtask

   task automatic fend();
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
   endtask

   task automatic drain(input bit backpressure);
      int k;
      k = 0;
      while (dump_m && k < 200) begin
         out_ready = backpressure ? (k % 3 == 0) : 1'b1;
         step();
         k++;
      end
      out_ready = 1'b1;
      chk("drain_done", 32'(dump_m), 32'd0);
   endtask

   task automatic basic_frame();
      pix(0);
      pix(14);
      pix(15);
      pix(120);
      pix(239);
   endtask

   initial begin
      int beats;
      for (int i = 0; i < 16; i++) begin
         live_m[i]   = 0;
         shadow_m[i] = 0;
      end
      dump_m = 0; idx_m = 0; bad_m = 0; ovr_m = 0;

      // reset state
      rst = 1'b1;
      step();
      step();
      chk("reset_out_bin", 32'(out_bin_a), 32'd0);
      chk("reset_out_count", 32'(out_count_a), 32'd0);
      chk("reset_out_last", 32'(out_last_a), 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      step();

      // basic bins, no backpressure: exactly 16 consecutive beats
      basic_frame();
      fend();
      beats = 0;
      while (out_valid_a && beats < 20) begin
         beats++;
         step();
      end
      chk("basic_beats", 32'(beats), 32'd16);
      chk("basic_bin0_expect", 32'(shadow_m[0]), 32'd2);

      // same frame under 1,0,0 backpressure
      basic_frame();
      fend();
      drain(1'b1);

      // sample coincident with frame_end belongs to the ending frame
      hue = 8'd30; hue_valid = 1'b1; frame_end = 1'b1;
      step();
      hue_valid = 1'b0; frame_end = 1'b0;
      drain(1'b0);
      repeat (3) pix(30);
      fend();
      drain(1'b0);

      // saturation on the 4-bit instance
      repeat (20) pix(50);
      fend();
      drain(1'b0);

      // overrun: second frame_end mid-dump discards that frame
      pix(100);
      out_ready = 1'b0;
      fend();
      repeat (5) pix(200);
      fend();
      chk("overrun_flag", 32'(overrun_a), 32'd1);
      drain(1'b0);
      fend();
      drain(1'b0);

      // illegal hues, then reset in the middle of a dump
      pix(240);
      pix(255);
      pix(10);
      chk("bad_hue_set", 32'(bad_hue_a), 32'd1);
      fend();
      while (dump_m && idx_m < 5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_abort_valid", 32'(out_valid_a), 32'd0);
      step();
      fend();
      drain(1'b0);

      // random traffic with backpressure and occasional overruns
      for (int c = 0; c < 1500; c++) begin
         hue_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 31) == 0)      hue = 8'($urandom_range(240, 255));
         else if ($urandom_range(0, 1) == 0)  hue = 8'($urandom_range(45, 59));
         else                                 hue = 8'($urandom_range(0, 239));
         out_ready = ($urandom_range(0, 2) != 0);
         frame_end = ($urandom_range(0, 39) == 0);
         step();
      end
      hue_valid = 1'b0;
      frame_end = 1'b0;
      drain(1'b0);
      fend();
      drain(1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/hue_histogram.md
Name: hue_histogram

Overview:
- Downstream consumer of the RGB-to-hue converter. Bins a stream of 8-bit hue values (0..239 scale) into 16 equal-width bins per frame.
- At each frame boundary, snapshots the bins into a shadow bank and streams them out over a valid/ready interface, for auto white-balance and colour-statistics logic.
- The converter has no valid output, so the upstream wrapper delays the pixel valid to align with hue (3 clocks).

Parameters:
CNT_WIDTH, 20, width of each bin counter; counters saturate at 2^CNT_WIDTH-1
NUM_BINS, 16, number of bins; fixed at 16 (bin width 15 hue units), not to be overridden

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
hue  input  8  hue sample, legal range 0..239
hue_valid  input  1  hue is a valid pixel this cycle
frame_end  input  1  one-cycle pulse marking the last cycle of a frame
out_valid  output  1  out_bin/out_count/out_last valid
out_ready  input  1  downstream accepts the current beat
out_bin  output  4  bin index of current beat
out_count  output  CNT_WIDTH  count for out_bin
out_last  output  1  high on the bin-15 beat
bad_hue  output  1  sticky: a hue >= 240 was seen with hue_valid
overrun  output  1  sticky: frame_end arrived while a dump was in progress

Behaviour:
- Reset (clk edge with rst=1):
  - Live counters, shadow bank and dump index are 0.
  - out_valid=0, out_bin=0, out_count=0, out_last=0, bad_hue=0, overrun=0.
  - FSM goes to IDLE.
  - A reset mid-dump aborts the dump: out_valid=0 after that edge, no further beats.
- Binning, on each edge with hue_valid=1:
  - bin = floor(hue/15), exact for all 0..239 (0..14→0, 15..29→1, …, 225..239→15).
  - live[bin] increments by 1; if already at 2^CNT_WIDTH-1 it holds.
  - hue >= 240: no counter changes, bad_hue set to 1 and held until rst.
  - Accumulation runs continuously in every FSM state.
- Frame boundary (edge with frame_end=1):
  - A hue_valid on the same edge belongs to the ending frame and is included in the snapshot.
  - FSM in IDLE: shadow <= live (including the coincident sample), live cleared to 0, FSM -> DUMP.
  - FSM in DUMP: overrun set to 1 (sticky), live cleared to 0 (that frame's statistics are discarded), shadow and the dump in progress are untouched.
- FSM:
  - IDLE: out_valid=0. frame_end -> DUMP, index=0.
  - DUMP:
    - out_valid=1 from the edge after the snapshot; out_bin=index, out_count=shadow[index], out_last=(index==15).
    - Outputs are held stable while out_ready=0.
    - valid&ready with index<15: index+1 at the next edge.
    - valid&ready with index==15: FSM -> IDLE, out_valid=0 next cycle.
- Timing:
  - Dump with out_ready held high: 16 beats on 16 consecutive cycles, the first beat in the cycle after the frame_end edge.
  - Minimum frame spacing for no overrun: 17 cycles between frame_end pulses under no backpressure.
- frame_end while rst=1 is ignored.

Test Plan:
- Basic bins: after rst, hue_valid with hues {0,14,15,120,239}, then frame_end, out_ready=1 -> 16 consecutive beats with bin0=2, bin1=1, bin8=1, bin15=1, all other bins 0; out_last only on bin 15; out_valid=0 on the 17th cycle.
- Backpressure: same frame with out_ready toggling 1,0,0,1,… -> out_bin/out_count stable while out_ready=0, every bin delivered exactly once in order 0..15, identical counts.
- Coincident events: hue=30 with hue_valid on the same edge as frame_end -> bin2 count includes it. Next frame of 3 samples of hue=30 -> dump shows bin2=3 (live was cleared).
- Saturation: CNT_WIDTH=4, 20 samples of hue=50 then frame_end -> bin3=15, no wrap; other bins 0.
- Overrun: frame_end, then hold out_ready=0, feed hue=200 ×5, pulse frame_end again -> overrun=1. Dump still shows the first frame's counts; after the dump, next frame_end shows bin13=0 (discarded frame).
- Illegal hue and reset: hue=240 and 255 with hue_valid -> bad_hue=1, no bin changes. Assert rst mid-dump at beat 5 -> out_valid=0 the following cycle, bad_hue=0, overrun=0, the next dump shows all zeros.
